issue_queue: RTL

Instruction queue and issue controller between IF and the Issue stage. Buffers fetched instructions in a ring FIFO and presents the head to Issue only when the ROB, plus the RS or LSB slot that instruction needs, can accept it. Supplies back-pressure to IF and drops all buffered instructions on rollback.

---
 rtl/issue_queue_pkg.sv | 20 ++
 rtl/issue_queue_if.sv | 25 ++
 rtl/issue_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/issue_queue_pkg.sv
// Shared constants, entry payload and opcode decode for the issue queue.
package issue_queue_pkg;

    localparam int unsigned DEF_IQ_LOG = 4;
    localparam int unsigned XLEN       = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } iq_entry_t;

    // Loads and stores go to the LSB; everything else needs an RS slot.
    function automatic logic is_ls(input logic [XLEN-1:0] inst);
        return (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side push channel, downstream full flags and issue-side outputs.
interface issue_queue_if;
    import issue_queue_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            iq_full;
    logic            rob_full;
    logic            rs_full;
    logic            lsb_full;
    logic            inst_valid;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] pc_out;

    modport master (
        output if_valid, if_inst, if_pc, rob_full, rs_full, lsb_full,
        input  iq_full, inst_valid, inst_out, pc_out
    );

    modport slave (
        input  if_valid, if_inst, if_pc, rob_full, rs_full, lsb_full,
        output iq_full, inst_valid, inst_out, pc_out
    );
endinterface

// File: rtl/issue_queue.sv
// Ring-buffer instruction queue between fetch and issue; issues the head only
// when the ROB and the RS/LSB slot the head needs can both accept it.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned IQ_LOG = DEF_IQ_LOG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         rollback,
    issue_queue_if.slave iq
);

    localparam int unsigned DEPTH = 1 << IQ_LOG;
    localparam int unsigned CNT_W = IQ_LOG + 1;

    logic [IQ_LOG-1:0] head_q, head_d;
    logic [IQ_LOG-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    iq_entry_t         mem_q [DEPTH];
    iq_entry_t         mem_d [DEPTH];

    iq_entry_t head_entry;
    logic      head_is_ls;
    logic      full_c;
    logic      slot_free_c;
    logic      push_c;
    logic      pop_c;
    logic      flush_c;

    // Head decode and handshake qualification, all off registered state.
    always_comb begin
        head_entry  = mem_q[head_q];
        head_is_ls  = is_ls(head_entry.inst);
        full_c      = (count_q == CNT_W'(DEPTH));
        slot_free_c = !iq.rob_full && (head_is_ls ? !iq.lsb_full : !iq.rs_full);
        flush_c     = rdy && rollback;
        pop_c       = rdy && !rollback && (count_q != '0) && slot_free_c;
        push_c      = rdy && !rollback && iq.if_valid && !full_c;
    end

    assign iq.iq_full    = full_c;
    assign iq.inst_valid = pop_c;
    assign iq.inst_out   = head_entry.inst;
    assign iq.pc_out     = head_entry.pc;

    // Pointer, occupancy and storage next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush_c) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                mem_d[tail_q] = '{inst: iq.if_inst, pc: iq.if_pc};
                tail_d        = tail_q + IQ_LOG'(1);
            end
            if (pop_c) begin
                head_d = head_q + IQ_LOG'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; stale entries are never issued.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
